// File: rtl/gold_collect_counter.sv
// gold_collect_counter: write side of the HUD gold count.
// Counts collected gold once per frame (saturating at MAX_GOLD), serves
// spend requests with a req/ack/nack handshake and fires a one-shot win pulse.
// Optional feature macro: GOLD_DECAY_EN adds a per-frame idle decay of the count.
// Inputs are registered once; events act on the registered copies, so an input
// sampled at edge N is reflected on the (registered) outputs after edge N+1.
module gold_collect_counter #(
    parameter int MAX_GOLD     = 4,
    parameter int WIN_COUNT    = 4,
    parameter int SPEND_COST   = 2,
    parameter int DECAY_FRAMES = 120
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       collision_gold,
    input  logic       spend_req,
    input  logic       level_restart,
    output logic [2:0] more_gold,
    output logic       gold_full,
    output logic       spend_ack,
    output logic       spend_nack,
    output logic       win_pulse
);

    typedef enum logic {ST_PLAY, ST_WON} main_state_t;
    typedef enum logic {SP_IDLE, SP_WAIT_LOW} spend_state_t;

    localparam logic [3:0] MAX4  = 4'(MAX_GOLD);
    localparam logic [3:0] WIN4  = 4'(WIN_COUNT);
    localparam logic [3:0] COST4 = 4'(SPEND_COST);

    // Reject parameter sets the 3-bit count cannot represent.
    generate
        if (MAX_GOLD > 7 || MAX_GOLD < 1 || WIN_COUNT > MAX_GOLD ||
            SPEND_COST < 1 || DECAY_FRAMES < 1) begin : g_bad_params
            $error("gold_collect_counter: illegal parameter combination");
        end
    endgenerate

    // Registered copies of the inputs plus collision history.
    logic         r_sof_s;
    logic         r_coll_s;
    logic         r_coll_prev;
    logic         r_spend_s;
    logic         r_restart_s;

    // Architectural state and registered outputs.
    logic [2:0]   r_count;
    logic         r_frame_lock;
    logic         r_full;
    logic         r_ack;
    logic         r_nack;
    logic         r_win;
    main_state_t  r_main_state;
    spend_state_t r_sp_state;

    // Combinational next-state terms.
    logic         w_rise;
    logic         w_collect;
    logic         w_grant;
    logic         w_refuse;
    logic         w_win;
    logic [3:0]   w_count4;
    logic [3:0]   w_inc4;
    logic [3:0]   w_net4;
    logic [3:0]   w_final4;

`ifdef GOLD_DECAY_EN
    localparam int DW = $clog2(DECAY_FRAMES + 1);
    localparam logic [DW-1:0] DF_W = DW'(DECAY_FRAMES);
    logic [DW-1:0] r_decay_cnt;
    logic [DW-1:0] w_decay_inc;
    logic [DW-1:0] w_decay_next;
`endif

    assign more_gold  = r_count;
    assign gold_full  = r_full;
    assign spend_ack  = r_ack;
    assign spend_nack = r_nack;
    assign win_pulse  = r_win;

    // Collect / spend / win arithmetic on the pre-update count, 4-bit wide.
    always_comb begin
        w_rise    = r_coll_s & ~r_coll_prev;
        // A startOfFrame in the same cycle releases the lock before the edge is judged.
        w_collect = w_rise & ~(r_frame_lock & ~r_sof_s) & (r_main_state == ST_PLAY);
        w_count4  = {1'b0, r_count};
        w_inc4    = w_count4;
        if (w_collect) begin
            w_inc4 = (w_count4 + 4'd1 > MAX4) ? MAX4 : (w_count4 + 4'd1);
        end
        w_grant  = (r_sp_state == SP_IDLE) & r_spend_s & (w_count4 >= COST4);
        w_refuse = (r_sp_state == SP_IDLE) & r_spend_s & (w_count4 <  COST4);
        // Grant eligibility guarantees w_inc4 >= COST4, so no underflow here.
        w_net4   = w_grant ? (w_inc4 - COST4) : w_inc4;
        w_win    = (r_main_state == ST_PLAY) & (w_net4 == WIN4) & (w_count4 < WIN4);
        w_final4 = w_net4;
`ifdef GOLD_DECAY_EN
        w_decay_inc  = r_decay_cnt + DW'(1);
        w_decay_next = r_decay_cnt;
        if (w_collect) begin
            w_decay_next = '0;
        end else if (r_sof_s) begin
            if (w_decay_inc == DF_W) begin
                w_decay_next = '0;
                // A grant this cycle takes precedence; the decay step is dropped.
                if (!w_grant && w_net4 != 4'd0) begin
                    w_final4 = w_net4 - 4'd1;
                end
            end else begin
                w_decay_next = w_decay_inc;
            end
        end
`endif
    end

    // Input capture, both FSMs and the registered outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_sof_s      <= 1'b0;
            r_coll_s     <= 1'b0;
            r_coll_prev  <= 1'b0;
            r_spend_s    <= 1'b0;
            r_restart_s  <= 1'b0;
            r_count      <= 3'd0;
            r_frame_lock <= 1'b0;
            r_full       <= 1'b0;
            r_ack        <= 1'b0;
            r_nack       <= 1'b0;
            r_win        <= 1'b0;
            r_main_state <= ST_PLAY;
            r_sp_state   <= SP_IDLE;
`ifdef GOLD_DECAY_EN
            r_decay_cnt  <= '0;
`endif
        end else begin
            r_sof_s     <= startOfFrame;
            r_coll_s    <= collision_gold;
            r_coll_prev <= r_coll_s;
            r_spend_s   <= spend_req;
            r_restart_s <= level_restart;
            if (r_restart_s) begin
                // New level: clear everything and make a held request wait for release.
                r_count      <= 3'd0;
                r_frame_lock <= 1'b0;
                r_full       <= 1'b0;
                r_ack        <= 1'b0;
                r_nack       <= 1'b0;
                r_win        <= 1'b0;
                r_main_state <= ST_PLAY;
                r_sp_state   <= SP_WAIT_LOW;
`ifdef GOLD_DECAY_EN
                r_decay_cnt  <= '0;
`endif
            end else begin
                r_count <= w_final4[2:0];
                r_full  <= (w_final4 == MAX4);
                r_ack   <= w_grant;
                r_nack  <= w_refuse;
                r_win   <= w_win;
                if (w_collect) begin
                    r_frame_lock <= 1'b1;
                end else if (r_sof_s) begin
                    r_frame_lock <= 1'b0;
                end
                if (w_win) begin
                    r_main_state <= ST_WON;
                end
                case (r_sp_state)
                    SP_IDLE:     if (r_spend_s)  r_sp_state <= SP_WAIT_LOW;
                    SP_WAIT_LOW: if (!r_spend_s) r_sp_state <= SP_IDLE;
                    default:     r_sp_state <= SP_IDLE;
                endcase
`ifdef GOLD_DECAY_EN
                r_decay_cnt <= w_decay_next;
`endif
            end
        end
    end

endmodule

// File: tb/tb_gold_collect_counter.sv
// Testbench for gold_collect_counter: directed stimulus, a frame-level
// behavioural model compared every cycle, plus literal checks of key results.
// With GOLD_DECAY_EN defined the decay scenario runs as well.
module tb_gold_collect_counter;

    localparam int MAXG = 4;
    localparam int WINC = 4;
    localparam int COST = 2;
    localparam int DF   = 3;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       startOfFrame = 1'b0;
    logic       collision_gold = 1'b0;
    logic       spend_req = 1'b0;
    logic       level_restart = 1'b0;
    logic [2:0] more_gold;
    logic       gold_full;
    logic       spend_ack;
    logic       spend_nack;
    logic       win_pulse;

    int n_vec  = 0;
    int n_miss = 0;
    int ack_seen = 0;
    int nack_seen = 0;
    int win_seen = 0;

    // Model state: what the game rules say the counter holds.
    int m_gold = 0, m_frames = 0;
    bit m_locked = 0, m_won = 0, m_waiting = 0;
    bit m_ack = 0, m_nack = 0, m_win = 0;
    // Inputs as the design registered them (one cycle of input latency).
    bit d_sof = 0, d_coll = 0, d_coll_prev = 0, d_spend = 0, d_restart = 0;

    gold_collect_counter #(
        .MAX_GOLD(MAXG), .WIN_COUNT(WINC), .SPEND_COST(COST), .DECAY_FRAMES(DF)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .collision_gold(collision_gold), .spend_req(spend_req),
        .level_restart(level_restart), .more_gold(more_gold),
        .gold_full(gold_full), .spend_ack(spend_ack),
        .spend_nack(spend_nack), .win_pulse(win_pulse)
    );

    always #5 clk = ~clk;

    // Behavioural model, advanced once per rising clock edge.
    initial begin
        forever begin
            @(posedge clk or negedge resetN);
            if (!resetN) begin
                m_gold = 0; m_frames = 0; m_locked = 0; m_won = 0; m_waiting = 0;
                m_ack = 0; m_nack = 0; m_win = 0;
                d_sof = 0; d_coll = 0; d_coll_prev = 0; d_spend = 0; d_restart = 0;
            end else begin
                if (d_restart) begin
                    m_gold = 0; m_locked = 0; m_won = 0; m_waiting = 1; m_frames = 0;
                    m_ack = 0; m_nack = 0; m_win = 0;
                end else begin
                    int  old_gold;
                    bit  collect;
                    old_gold = m_gold;
                    if (d_sof) m_locked = 0;
                    collect = d_coll && !d_coll_prev && !m_locked && !m_won;
                    if (collect) begin
                        m_gold   = (m_gold + 1 > MAXG) ? MAXG : m_gold + 1;
                        m_locked = 1;
                        m_frames = 0;
                    end
                    m_ack = 0; m_nack = 0;
                    if (!m_waiting && d_spend) begin
                        if (old_gold >= COST) begin
                            m_ack  = 1;
                            m_gold = m_gold - COST;
                        end else begin
                            m_nack = 1;
                        end
                        m_waiting = 1;
                    end else if (m_waiting && !d_spend) begin
                        m_waiting = 0;
                    end
                    m_win = !m_won && collect && (m_gold == WINC) && (old_gold < WINC);
                    if (m_win) m_won = 1;
`ifdef GOLD_DECAY_EN
                    if (!collect && d_sof) begin
                        m_frames++;
                        if (m_frames == DF) begin
                            m_frames = 0;
                            if (!m_ack && m_gold > 0) m_gold--;
                        end
                    end
`endif
                end
                d_coll_prev = d_coll;
                d_coll      = collision_gold;
                d_sof       = startOfFrame;
                d_spend     = spend_req;
                d_restart   = level_restart;
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (resetN) begin
                logic [6:0] exp_v, act_v;
                exp_v = {3'(m_gold), (m_gold == MAXG), m_ack, m_nack, m_win};
                act_v = {more_gold, gold_full, spend_ack, spend_nack, win_pulse};
                n_vec++;
                if (act_v !== exp_v) begin
                    n_miss++;
                    $display("FAIL cycle_model t=%0t got gold=%0d full=%b ack=%b nack=%b win=%b required gold=%0d full=%b ack=%b nack=%b win=%b",
                             $time, act_v[6:4], act_v[3], act_v[2], act_v[1], act_v[0],
                             exp_v[6:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
                end
                if (spend_ack)  ack_seen++;
                if (spend_nack) nack_seen++;
                if (win_pulse)  win_seen++;
            end
        end
    end

    task automatic check(input string name, input int actual, input int required);
        n_vec++;
        if (actual != required) begin
            n_miss++;
            $display("FAIL %s got %0d required %0d", name, actual, required);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        step(1);
        startOfFrame = 1'b0;
        step(2);
    endtask

    task automatic restart();
        level_restart = 1'b1;
        step(1);
        level_restart = 1'b0;
        step(2);
    endtask

    task automatic collect_one();
        collision_gold = 1'b1;
        step(2);
        collision_gold = 1'b0;
        step(2);
        frame();
    endtask

    initial begin
        int a0, n0, w0;
        // Reset state
        step(2);
        check("reset_gold", more_gold, 0);
        check("reset_flags", {gold_full, spend_ack, spend_nack, win_pulse}, 0);
        resetN = 1'b1;
        step(1);

        // 1: held collision over three frames counts once
        w0 = win_seen;
        collision_gold = 1'b1;
        step(3);
        frame(); frame(); frame();
`ifndef GOLD_DECAY_EN
        check("held_collision_gold", more_gold, 1);
`endif
        check("held_collision_no_win", win_seen - w0, 0);
        collision_gold = 1'b0;
        step(2);

        // 2: four edges in four frames reach the win, fifth saturates
        restart();
        w0 = win_seen;
        for (int i = 1; i <= 4; i++) begin
            collect_one();
`ifndef GOLD_DECAY_EN
            check($sformatf("collect_%0d", i), more_gold, i);
`endif
        end
`ifndef GOLD_DECAY_EN
        check("full_at_max", gold_full, 1);
`endif
        check("single_win", win_seen - w0, 1);
        collect_one();
`ifndef GOLD_DECAY_EN
        check("saturate", more_gold, 4);
`endif
        check("no_second_win", win_seen - w0, 1);

        // 3: frame lock, then coincident startOfFrame and edge
        restart();
        collision_gold = 1'b1; step(2); collision_gold = 1'b0; step(2);
        collision_gold = 1'b1; step(2); collision_gold = 1'b0; step(2);
        check("same_frame_once", more_gold, 1);
        collision_gold = 1'b1; startOfFrame = 1'b1;
        step(1);
        startOfFrame = 1'b0;
        step(1);
        collision_gold = 1'b0;
        step(2);
        check("sof_coincident", more_gold, 2);

        // 4: held spend served once, then refused
        restart();
        collect_one(); collect_one(); collect_one();
        a0 = ack_seen; n0 = nack_seen;
        spend_req = 1'b1; step(10); spend_req = 1'b0; step(3);
        check("held_spend_acks", ack_seen - a0, 1);
`ifndef GOLD_DECAY_EN
        check("after_spend", more_gold, 1);
`endif
        spend_req = 1'b1; step(4); spend_req = 1'b0; step(3);
        check("refuse_nacks", nack_seen - n0, 1);
        check("refuse_acks", ack_seen - a0, 1);

        // 5: collect and grant together; restart during a held request
        restart();
        collect_one(); collect_one();
        a0 = ack_seen;
        collision_gold = 1'b1; spend_req = 1'b1;
        step(3);
        collision_gold = 1'b0; spend_req = 1'b0;
        step(3);
        check("collect_and_spend_ack", ack_seen - a0, 1);
`ifndef GOLD_DECAY_EN
        check("collect_and_spend_gold", more_gold, 1);
`endif
        a0 = ack_seen; n0 = nack_seen;
        spend_req = 1'b1; level_restart = 1'b1;
        step(1);
        level_restart = 1'b0;
        step(6);
        check("restart_gold", more_gold, 0);
        check("restart_suppress", (ack_seen - a0) + (nack_seen - n0), 0);
        spend_req = 1'b0; step(2);
        spend_req = 1'b1; step(3);
        spend_req = 1'b0; step(2);
        check("rearmed_nack", nack_seen - n0, 1);

`ifdef GOLD_DECAY_EN
        // 6: idle decay, one step every DF frames
        restart();
        collision_gold = 1'b1; step(2); collision_gold = 1'b0; step(2);
        frame();
        collision_gold = 1'b1; step(2); collision_gold = 1'b0; step(2);
        check("decay_start", more_gold, 2);
        frame(); frame(); frame();
        check("decay_one", more_gold, 1);
        frame(); frame(); frame();
        check("decay_two", more_gold, 0);
        frame(); frame(); frame();
        check("decay_floor", more_gold, 0);
`endif

        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/gold_collect_counter.md
Name: gold_collect_counter

Overview:
- Produces the gold count `more_gold` that the HUD gold-count drawing object renders. It is the write side of that interface.
- Takes player/gold collision requests from the collision matrix and frame timing from the VGA controller. Counts collected gold once per frame, saturating. Serves spend requests from game logic with a req/ack/nack handshake. Raises a one-shot win event.
- Sits between the collision/game-control logic and the HUD object.

Parameters:
- MAX_GOLD, default 4: saturation ceiling of the count; must be ≤ 7 (3-bit output).
- WIN_COUNT, default 4: count value whose first arrival fires win_pulse; must be ≤ MAX_GOLD.
- SPEND_COST, default 2: gold removed per granted spend; must be ≥ 1.
- DECAY_FRAMES, default 120: idle frames per decay step (used only with GOLD_DECAY_EN).

Ports:
- clk, input, 1: system clock.
- resetN, input, 1: asynchronous active-low reset.
- startOfFrame, input, 1: one-cycle pulse at the start of each VGA frame.
- collision_gold, input, 1: level; high while player overlaps gold. May stay high for many cycles.
- spend_req, input, 1: level request to spend SPEND_COST gold.
- level_restart, input, 1: synchronous clear for a new level.
- more_gold, output, 3: current gold count, registered.
- gold_full, output, 1: high when more_gold == MAX_GOLD.
- spend_ack, output, 1: one-cycle grant pulse.
- spend_nack, output, 1: one-cycle refuse pulse.
- win_pulse, output, 1: one-cycle pulse on first arrival at WIN_COUNT.

Behaviour:
- Reset (resetN low, asynchronous): all outputs 0. count=0, frame_lock=0, collision history=0. Main FSM=PLAY, spend FSM=SP_IDLE.
- All outputs are registered. An event sampled at edge N shows on the outputs after edge N+1.
- Collect event = rising edge of collision_gold (registered previous value) while frame_lock=0 and main FSM=PLAY.
  - Sets frame_lock.
  - count := min(count+1, MAX_GOLD).
- frame_lock clears on startOfFrame. If startOfFrame and a collect edge coincide, the clear wins first and the collect is counted; the lock is then set again.
- Main FSM:
  - PLAY → WON when the next count equals WIN_COUNT and the current count is < WIN_COUNT. win_pulse=1 for exactly that cycle.
  - WON: collect events are ignored; spends are still served.
  - WON → PLAY only on level_restart.
- Spend FSM:
  - SP_IDLE with spend_req=1 and count ≥ SPEND_COST: spend_ack pulse, count -= SPEND_COST, go to SP_WAIT_LOW.
  - SP_IDLE with spend_req=1 and count < SPEND_COST: spend_nack pulse, go to SP_WAIT_LOW.
  - SP_WAIT_LOW → SP_IDLE when spend_req=0. A held request is served at most once.
- Collect and grant in the same cycle: net result is count = min(count+1, MAX_GOLD) − SPEND_COST. Eligibility is judged on the pre-update count. Win detection uses the net result.
- Saturation: collect at MAX_GOLD leaves count unchanged but still sets frame_lock. No wrap-around; count never goes below 0.
- level_restart has highest priority (below reset).
  - count=0, frame_lock=0, main FSM=PLAY, spend FSM=SP_WAIT_LOW.
  - Suppresses ack/nack/win in that cycle.
- Width rules: internal arithmetic is 4-bit unsigned, then clamped to 0..MAX_GOLD before storing.

Optional Feature:
- Macro: GOLD_DECAY_EN.
- Defined:
  - A frame counter counts startOfFrame pulses since the last counted collect. A collect or level_restart resets it to 0.
  - When it reaches DECAY_FRAMES: count decrements by 1 if count > 0, and the counter resets to 0.
  - Decay has lower priority than collect and spend in the same cycle and is skipped in that cycle.
  - Decay never re-arms win_pulse and never moves WON → PLAY.
- Undefined: no frame counter exists; the count changes only by collect, spend, level_restart and reset.

Test Plan:
- Reset, then hold collision_gold=1 for 3 frames → more_gold=1 after the first edge, stays 1, win_pulse never asserted.
- Four separate collision edges in four frames, WIN_COUNT=4 → more_gold 1,2,3,4; win_pulse exactly one cycle at the 4th; gold_full=1; a 5th edge leaves more_gold=4.
- Two collision edges in the same frame, with no startOfFrame between them → more_gold increments by 1 only. A startOfFrame coincident with the second edge → increments by 2 total.
- more_gold=3, spend_req held for 10 cycles → one spend_ack, more_gold=1. Release and request again → one spend_nack, more_gold stays 1.
- more_gold=2, collect edge and spend_req in the same cycle → spend_ack, more_gold=1. level_restart during held spend_req → more_gold=0, no ack/nack until spend_req drops and rises again.
- With GOLD_DECAY_EN and DECAY_FRAMES=3, more_gold=2 and no collisions → more_gold=1 after 3 frames, 0 after 6, stays 0.
